// File: rtl/instr_mem_loader_pkg.sv
// Shared instruction-memory constants and loader state encodings.
// instr_mem uses the same IMEM_DEPTH, so the loader's overflow bound always tracks the real array.
package instr_mem_loader_pkg;

  localparam int IMEM_DEPTH      = 1024;
  localparam int IMEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_FLUSH = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

  // Drop one stream byte into its little-endian lane of a 32-bit word.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    res[{lane, 3'b000} +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Lane counter and word assembler: emits a packed word combinationally on the byte that completes it.
// A word completes on lane 3 or on last; unfilled upper lanes stay zero because the buffer clears after each word.
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_dat,
  input  logic        last,
  output logic        word_vld,
  output logic        flush,
  output logic [31:0] word_dat
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] assembled;

  always_comb begin
    assembled = put_byte(buf_q, lane_q, byte_dat);
    word_vld  = take && ((lane_q == 2'd3) || last);
    flush     = take && last;
    word_dat  = assembled;
    lane_d    = lane_q;
    buf_d     = buf_q;
    if (clear) begin
      lane_d = '0;
      buf_d  = '0;
    end else if (word_vld) begin
      lane_d = '0;
      buf_d  = '0;
    end else if (take) begin
      lane_d = lane_q + 2'd1;
      buf_d  = assembled;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lane_q <= '0;
      buf_q  <= '0;
    end else begin
      lane_q <= lane_d;
      buf_q  <= buf_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream image loader for instr_mem: packs bytes into words, writes them 1 cycle after the completing byte.
// Holds the core via cpu_hold while loading; optional checksum output under LOADER_CHECKSUM_EN.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH      = IMEM_DEPTH,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  last,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_hold,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  err_overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  localparam int IW = ADDR_WIDTH - 2;

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic                  err_q, err_d;

  logic                  take;
  logic                  start_ok;
  logic                  pk_word_vld;
  logic                  pk_flush;
  logic [31:0]           pk_word_dat;
  logic [IW-1:0]         word_idx;
  logic                  word_oob;

  assign byte_ready = (state_q == LD_LOAD);
  assign take       = byte_valid && byte_ready;
  assign start_ok   = start && ((state_q == LD_IDLE) || (state_q == LD_DONE));

  instr_mem_loader_byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .take     (take),
    .byte_dat (byte_data),
    .last     (last),
    .word_vld (pk_word_vld),
    .flush    (pk_flush),
    .word_dat (pk_word_dat)
  );

  // Index of the word being completed; wraps with the address space like mem_addr does.
  assign word_idx = base_q[ADDR_WIDTH-1:2] + IW'(word_count_q);
  assign word_oob = (64'(word_idx) >= 64'(DEPTH));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_IDLE:  if (start_ok) state_d = LD_LOAD;
      LD_LOAD:  if (pk_flush) state_d = LD_FLUSH;
      LD_FLUSH: state_d = LD_DONE;
      LD_DONE:  state_d = start_ok ? LD_LOAD : LD_IDLE;
      default:  state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    base_d       = base_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    word_count_d = word_count_q;
    err_d        = err_q;
    if (start_ok) begin
      base_d       = base_addr & ~ADDR_WIDTH'(3);
      word_count_d = '0;
      err_d        = 1'b0;
    end
    // Out-of-range words still count and still consume their bytes so the stream drains.
    if (pk_word_vld) begin
      mem_wdata_d = pk_word_dat;
      mem_addr_d  = base_q + ADDR_WIDTH'(word_count_q) * ADDR_WIDTH'(IMEM_WORD_BYTES);
      mem_we_d    = !word_oob;
      if (word_oob) begin
        err_d = 1'b1;
      end
      if (word_count_q != '1) begin
        word_count_d = word_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= LD_IDLE;
      base_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_ok) begin
      checksum_d = '0;
    end else if (pk_word_vld) begin
      checksum_d = checksum_q + pk_word_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign word_count   = word_count_q;
  assign err_overflow = err_q;
  assign busy         = (state_q == LD_LOAD) || (state_q == LD_FLUSH);
  assign cpu_hold     = busy;
  assign done         = (state_q == LD_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: image-level model of expected writes, per-cycle write checker.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        last = 1'b0;
  logic        byte_ready, mem_we, busy, done, cpu_hold, err_overflow;
  logic [31:0] mem_addr, mem_wdata;
  logic [10:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instr_mem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .last         (last),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .cpu_hold     (cpu_hold),
    .word_count   (word_count),
    .err_overflow (err_overflow)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] act_log[$];
  logic [63:0] cmp_e;
  logic [7:0]  img[16];
  int          exp_wc;
  logic        exp_err;
  logic [31:0] exp_sum;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_img(input logic [127:0] v);
    for (int i = 0; i < 16; i++) img[i] = v[127-8*i -: 8];
  endtask

  // Model: the image is ceil(n/4) little-endian words at consecutive word addresses; words whose
  // index lands at or past 1024 are counted and summed but never written.
  task automatic build_model(input logic [31:0] base, input int n);
    logic [31:0] word;
    logic [31:0] idx;
    exp_q.delete();
    exp_sum = 0;
    exp_err = 1'b0;
    exp_wc  = (n + 3) / 4;
    for (int w = 0; w < exp_wc; w++) begin
      word = 0;
      for (int b = 0; b < 4; b++)
        if (4*w + b < n) word = word | (32'(img[4*w+b]) << (8*b));
      exp_sum = exp_sum + word;
      idx = (base >> 2) + 32'(w);
      if (idx < 32'd1024) exp_q.push_back({(base & ~32'h3) + 32'(4*w), word});
      else exp_err = 1'b1;
    end
  endtask

  // Every write the DUT issues must be the next one the model predicts.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) begin
        act_log.push_back({mem_addr, mem_wdata});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %h@%h expected none", mem_wdata, mem_addr);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("wr_addr", {32'h0, mem_addr}, {32'h0, cmp_e[63:32]});
          chk("wr_data", {32'h0, mem_wdata}, {32'h0, cmp_e[31:0]});
        end
      end
      if (done) begin
        done_cnt++;
        chk("hold_low_at_done", cpu_hold, 0);
      end
      if (busy) chk("hold_while_busy", cpu_hold, 1);
    end
  end

  task automatic pulse_start(input logic [31:0] base);
    act_log.delete();
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 32'hDEAD_BEE0;
    chk("hold_after_start", cpu_hold, 1);
    chk("err_cleared_by_start", err_overflow, 0);
    chk("wc_cleared_by_start", word_count, 0);
  endtask

  task automatic send_bytes(input int n, input int nsend, input int gap_max, input int restart_at);
    int to;
    for (int i = 0; i < nsend; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_data  = img[i];
      last       = (i == n - 1);
      if (i == restart_at) begin
        start = 1'b1;
        base_addr = 32'h400;
      end
      to = 0;
      @(negedge clk);
      while (!byte_ready && to < 20) begin
        to++;
        @(negedge clk);
      end
      if (to >= 20) begin
        checks++;
        errors++;
        $display("FAIL byte_ready_timeout: got 0 expected 1 (byte %0d)", i);
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
      last = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int to;
    int seen;
    seen = done_cnt;
    to = 0;
    @(negedge clk);
    while (!done && to < 10) begin
      to++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_word_count"}, 64'(word_count), 64'(exp_wc));
    chk({tag, "_err_overflow"}, err_overflow, exp_err);
`ifdef LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, exp_sum);
`endif
    @(negedge clk); #1;
    chk({tag, "_done_one_pulse"}, done, 0);
    chk({tag, "_hold_after_done"}, cpu_hold, 0);
    chk({tag, "_done_count"}, 64'(done_cnt - seen), 1);
    chk({tag, "_all_writes_issued"}, 64'(exp_q.size()), 0);
  endtask

  task automatic run_image(input string tag, input logic [31:0] base, input int n,
                           input int gap_max, input int restart_at);
    build_model(base, n);
    pulse_start(base);
    send_bytes(n, n, gap_max, restart_at);
    wait_done(tag);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_outputs", {busy, done, cpu_hold, err_overflow, byte_ready}, 0);
    chk("rst_word_count", 64'(word_count), 0);
    chk("rst_addr_data", {mem_addr, mem_wdata}, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    load_img(128'h13050000_93051000_00000000_00000000);
    run_image("t1", 32'h0, 8, 0, -1);
    chk("t1_nwrites", 64'(act_log.size()), 2);
    chk("t1_w0", act_log[0], {32'h0, 32'h00000513});
    chk("t1_w1", act_log[1], {32'h4, 32'h00100593});
`ifdef LOADER_CHECKSUM_EN
    chk("t1_checksum_literal", checksum, 32'h00100AA6);
`endif

    load_img(128'hAABBCCDD_11220000_00000000_00000000);
    run_image("t2", 32'h10, 6, 0, -1);
    chk("t2_w0", act_log[0], {32'h10, 32'hDDCCBBAA});
    chk("t2_w1", act_log[1], {32'h14, 32'h00002211});

    run_image("t3_gaps", 32'h13, 6, 3, -1);
    chk("t3_w1", act_log[1], {32'h14, 32'h00002211});

    load_img(128'h01020304_05060708_090A0B0C_0D0E0F10);
    run_image("restart_ignored", 32'h20, 13, 1, 3);
    chk("restart_w3", act_log[3], {32'h2C, 32'h0000000D});

    load_img(128'h11111111_22222222_00000000_00000000);
    run_image("t4_ovf", 32'hFFC, 8, 0, -1);
    chk("t4_nwrites", 64'(act_log.size()), 1);
    chk("t4_w0", act_log[0], {32'hFFC, 32'h11111111});
    chk("t4_err_sticky", err_overflow, 1);

    load_img(128'h13050000_93051000_00000000_00000000);
    run_image("t4_clear", 32'h0, 8, 0, -1);

    load_img(128'hA1A2A3A4_B1000000_00000000_00000000);
    build_model(32'h100, 4);
    seen = done_cnt;
    pulse_start(32'h100);
    send_bytes(8, 5, 0, -1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t5_mem_we", mem_we, 0);
    chk("t5_outputs", {busy, done, cpu_hold, err_overflow, byte_ready}, 0);
    chk("t5_word_count", 64'(word_count), 0);
    chk("t5_addr_data", {mem_addr, mem_wdata}, 0);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_one_write", 64'(act_log.size()), 1);
    chk("t5_w0", act_log[0], {32'h100, 32'hA4A3A2A1});
    chk("t5_no_done", 64'(done_cnt - seen), 0);
    chk("t5_idle_hold", cpu_hold, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
